// File: rtl/persiana_ctrl.sv
// Blind/shutter command generator: debounces up/down/stop buttons and runs the
// travel FSM that drives the motor stage, with a travel watchdog.
module persiana_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_stop,
  input  logic       TopeA_S,
  input  logic       TopeB_S,
  output logic [1:0] cmd,
  output logic [1:0] estado,
  output logic       busy,
  output logic       fault
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TM_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SUBE  = 2'b01,
    ST_BAJA  = 2'b10,
    ST_FALLA = 2'b11
  } state_t;

  // Button index: 0 = up, 1 = down, 2 = stop
  logic [2:0] w_raw;
  logic [2:0] r_sync_p0;
  logic [2:0] r_sync_p1;
  logic [2:0] r_db;
  logic [2:0] r_db_p2;
  logic [2:0] r_press;

  assign w_raw = {btn_stop, btn_down, btn_up};

  // Stage p0/p1: two-flop synchronizer on the raw asynchronous buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_debounce
      logic [DB_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt   <= '0;
          r_db[g] <= 1'b0;
        end else if (r_sync_p1[g] == r_db[g]) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
          r_db[g] <= r_sync_p1[g];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end
    end
  endgenerate

  // Stage p2: rising-edge detect on the debounced levels, one-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_p2 <= '0;
      r_press <= '0;
    end else begin
      r_db_p2 <= r_db;
      r_press <= r_db & ~r_db_p2;
    end
  end

  logic w_press_up;
  logic w_press_down;
  logic w_press_stop;

  assign w_press_up   = r_press[0];
  assign w_press_down = r_press[1];
  assign w_press_stop = r_press[2];

  state_t          r_state;
  state_t          w_next;
  logic [TM_W-1:0] r_timer;
  logic [TM_W-1:0] w_timer_nxt;
  logic            w_timeout;

  assign w_timeout = (r_timer == TM_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_press_stop)                     w_next = ST_IDLE;
        else if (w_press_up && w_press_down)  w_next = ST_IDLE;
        else if (w_press_up && !TopeA_S)      w_next = ST_SUBE;
        else if (w_press_down && !TopeB_S)    w_next = ST_BAJA;
      end
      ST_SUBE: begin
        if (TopeA_S && TopeB_S)  w_next = ST_FALLA;
        else if (w_press_stop)   w_next = ST_IDLE;
        else if (TopeA_S)        w_next = ST_IDLE;
        else if (w_press_down)   w_next = ST_IDLE;
        else if (w_timeout)      w_next = ST_FALLA;
      end
      ST_BAJA: begin
        if (TopeA_S && TopeB_S)  w_next = ST_FALLA;
        else if (w_press_stop)   w_next = ST_IDLE;
        else if (TopeB_S)        w_next = ST_IDLE;
        else if (w_press_up)     w_next = ST_IDLE;
        else if (w_timeout)      w_next = ST_FALLA;
      end
      ST_FALLA: begin
        if (w_press_stop)        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Timer restarts on entry to a travel state, since reversal always goes via IDLE
  always_comb begin
    w_timer_nxt = '0;
    if ((w_next == ST_SUBE || w_next == ST_BAJA) && (w_next == r_state))
      w_timer_nxt = r_timer + TM_W'(1);
  end

  logic [1:0] r_cmd;
  logic       r_busy;
  logic       r_fault;

  // Stage p3: state and all outputs registered from the same next-state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_cmd   <= 2'b00;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= w_timer_nxt;
      r_cmd   <= (w_next == ST_SUBE || w_next == ST_BAJA) ? w_next : 2'b00;
      r_busy  <= (w_next == ST_SUBE || w_next == ST_BAJA);
      r_fault <= (w_next == ST_FALLA);
    end
  end

  assign cmd    = r_cmd;
  assign estado = r_state;
  assign busy   = r_busy;
  assign fault  = r_fault;

endmodule

// File: tb/tb_persiana_ctrl.sv
// Bench for persiana_ctrl: directed vector table, a cycle-exact latency
// sequence and randomized buttons/limits checked against a behavioural model.
module tb_persiana_ctrl;

  localparam int DB = 4;
  localparam int TO = 16;
  localparam int S_IDLE  = 0;
  localparam int S_SUBE  = 1;
  localparam int S_BAJA  = 2;
  localparam int S_FALLA = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       btn_stop;
  logic       TopeA_S;
  logic       TopeB_S;
  logic [1:0] cmd;
  logic [1:0] estado;
  logic       busy;
  logic       fault;

  persiana_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_stop(btn_stop),
    .TopeA_S (TopeA_S),
    .TopeB_S (TopeB_S),
    .cmd     (cmd),
    .estado  (estado),
    .busy    (busy),
    .fault   (fault)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural reference: button history windows and an entry timestamp
  int          m_state = S_IDLE;
  int          m_cyc   = 0;
  int          m_entry = 0;
  bit          m_raw1 [3];
  bit          m_raw2 [3];
  bit          m_db   [3];
  bit          m_dbd  [3];
  bit          m_press[3];
  logic [31:0] m_hist [3];
  int          m_len  [3];

  task automatic model_step();
    bit raw[3];
    bit pu, pd, ps, s, all_diff;
    int nxt;
    raw[0] = btn_up;
    raw[1] = btn_down;
    raw[2] = btn_stop;
    m_cyc++;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_raw1[i] = 0; m_raw2[i] = 0; m_db[i] = 0; m_dbd[i] = 0;
        m_press[i] = 0; m_hist[i] = '0; m_len[i] = 0;
      end
      m_state = S_IDLE;
      m_entry = 0;
      return;
    end
    pu = m_press[0];
    pd = m_press[1];
    ps = m_press[2];
    for (int i = 0; i < 3; i++) begin
      s = m_raw2[i];
      m_press[i] = m_db[i] & ~m_dbd[i];
      m_dbd[i] = m_db[i];
      m_hist[i] = {m_hist[i][30:0], s};
      m_len[i]++;
      if (m_len[i] >= DB) begin
        all_diff = 1;
        for (int j = 0; j < DB; j++)
          if (m_hist[i][j] == m_db[i]) all_diff = 0;
        if (all_diff) begin
          m_db[i] = s;
          m_len[i] = 0;
        end
      end
      m_raw2[i] = m_raw1[i];
      m_raw1[i] = raw[i];
    end
    nxt = m_state;
    case (m_state)
      S_IDLE: begin
        if (ps || (pu && pd)) nxt = S_IDLE;
        else if (pu && !TopeA_S) nxt = S_SUBE;
        else if (pd && !TopeB_S) nxt = S_BAJA;
      end
      S_SUBE, S_BAJA: begin
        if (TopeA_S && TopeB_S) nxt = S_FALLA;
        else if (ps) nxt = S_IDLE;
        else if (m_state == S_SUBE && (TopeA_S || pd)) nxt = S_IDLE;
        else if (m_state == S_BAJA && (TopeB_S || pu)) nxt = S_IDLE;
        else if (m_cyc - m_entry == TO) nxt = S_FALLA;
      end
      default: if (ps) nxt = S_IDLE;
    endcase
    if ((nxt == S_SUBE || nxt == S_BAJA) && nxt != m_state) m_entry = m_cyc;
    m_state = nxt;
  endtask

  task automatic check_model();
    logic [1:0] ecmd, eest;
    logic       ebusy, efault;
    int         st;
    st     = m_state;
    eest   = st[1:0];
    ebusy  = (st == S_SUBE || st == S_BAJA);
    efault = (st == S_FALLA);
    ecmd   = ebusy ? eest : 2'b00;
    n_chk++;
    if (cmd === ecmd && estado === eest && busy === ebusy && fault === efault)
      n_pass++;
    else
      $display("FAIL model cyc=%0d got cmd=%b estado=%b busy=%b fault=%b want cmd=%b estado=%b busy=%b fault=%b",
               m_cyc, cmd, estado, busy, fault, ecmd, eest, ebusy, efault);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic check_out(input string name, input logic [1:0] ecmd, input logic [1:0] eest,
                           input logic ebusy, input logic efault);
    n_chk++;
    if (cmd === ecmd && estado === eest && busy === ebusy && fault === efault)
      n_pass++;
    else
      $display("FAIL %s got cmd=%b estado=%b busy=%b fault=%b want cmd=%b estado=%b busy=%b fault=%b",
               name, cmd, estado, busy, fault, ecmd, eest, ebusy, efault);
  endtask

  typedef struct {
    bit         rst, up, dn, st, ta, tb;
    int         n;
    logic [1:0] cmd, est;
    bit         busy, fault;
  } vec_t;

  vec_t vt[$];

  task automatic v(input bit r, input bit u, input bit d, input bit s, input bit a,
                   input bit b, input int n, input logic [1:0] es);
    vec_t x;
    x.rst = r; x.up = u; x.dn = d; x.st = s; x.ta = a; x.tb = b; x.n = n;
    x.est   = es;
    x.busy  = (es == 2'b01 || es == 2'b10);
    x.fault = (es == 2'b11);
    x.cmd   = x.busy ? es : 2'b00;
    vt.push_back(x);
  endtask

  initial begin
    reset = 1'b1; btn_up = 1'b1; btn_down = 1'b0; btn_stop = 1'b0;
    TopeA_S = 1'b0; TopeB_S = 1'b0;

    //  rst up dn st ta tb   n  estado
    v(1, 1, 0, 0, 0, 0,   2, 2'b00);  // reset with up held
    v(0, 1, 0, 0, 0, 0,   7, 2'b00);
    v(0, 1, 0, 0, 0, 0,   1, 2'b01);  // SUBE on 8th edge
    v(0, 1, 0, 0, 1, 0,   1, 2'b00);  // top limit stops next edge
    v(0, 1, 0, 0, 0, 0, 100, 2'b00);  // held button: no second pulse
    v(0, 0, 0, 0, 0, 0,  10, 2'b00);
    v(0, 1, 0, 0, 0, 0,   3, 2'b00);  // 3-cycle glitch
    v(0, 0, 0, 0, 0, 0,  10, 2'b00);
    v(0, 0, 0, 0, 1, 0,  10, 2'b00);
    v(0, 1, 0, 0, 1, 0,  12, 2'b00);  // up toward active top limit
    v(0, 0, 1, 0, 1, 0,   7, 2'b00);
    v(0, 0, 1, 0, 1, 0,   1, 2'b10);  // down allowed
    v(0, 0, 0, 0, 0, 0,   6, 2'b10);
    v(0, 1, 0, 0, 0, 0,   7, 2'b10);
    v(0, 1, 0, 0, 0, 0,   1, 2'b00);  // reversal lands in IDLE
    v(0, 1, 0, 0, 0, 0,  20, 2'b00);
    v(0, 0, 0, 0, 0, 0,   8, 2'b00);
    v(0, 1, 0, 1, 0, 0,  12, 2'b00);  // stop + up together
    v(0, 0, 0, 0, 0, 0,   8, 2'b00);
    v(0, 0, 1, 0, 0, 0,   8, 2'b10);
    v(0, 0, 1, 0, 0, 0,  15, 2'b10);
    v(0, 0, 1, 0, 0, 0,   1, 2'b11);  // watchdog at entry+16
    v(0, 0, 0, 0, 0, 0,   6, 2'b11);
    v(0, 1, 0, 0, 0, 0,  12, 2'b11);  // up ignored in FALLA
    v(0, 0, 0, 0, 0, 0,   6, 2'b11);
    v(0, 0, 0, 1, 0, 0,   7, 2'b11);
    v(0, 0, 0, 1, 0, 0,   1, 2'b00);  // stop clears fault
    v(0, 0, 0, 0, 0, 0,   8, 2'b00);
    v(0, 1, 0, 0, 0, 0,   8, 2'b01);
    v(0, 0, 0, 0, 1, 1,   1, 2'b11);  // both limits while travelling
    v(0, 0, 0, 1, 0, 0,   8, 2'b00);
    v(0, 0, 0, 0, 0, 0,   8, 2'b00);
    v(0, 0, 1, 0, 0, 0,   8, 2'b10);
    v(1, 0, 1, 0, 0, 0,   1, 2'b00);  // reset mid-travel
    v(0, 0, 1, 0, 0, 0,   8, 2'b10);
    v(0, 0, 1, 0, 0, 0,  15, 2'b10);  // timer restarted after reset
    v(0, 0, 1, 0, 0, 0,   1, 2'b11);
    v(0, 0, 0, 1, 1, 1,   8, 2'b00);
    v(0, 0, 0, 0, 1, 1,   5, 2'b00);  // both limits in IDLE: no fault
    v(0, 1, 0, 0, 1, 1,  12, 2'b00);
    v(0, 0, 1, 0, 1, 1,  12, 2'b00);

    foreach (vt[k]) begin
      reset = vt[k].rst; btn_up = vt[k].up; btn_down = vt[k].dn;
      btn_stop = vt[k].st; TopeA_S = vt[k].ta; TopeB_S = vt[k].tb;
      repeat (vt[k].n) tick();
      check_out($sformatf("vec%0d", k), vt[k].cmd, vt[k].est, vt[k].busy, vt[k].fault);
    end

    // Edge-by-edge latency from first sample of the raw level
    reset = 0; btn_up = 0; btn_down = 0; btn_stop = 0; TopeA_S = 0; TopeB_S = 0;
    repeat (10) tick();
    btn_up = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) check_out($sformatf("latency_e%0d", k), 2'b01, 2'b01, 1'b1, 1'b0);
      else        check_out($sformatf("latency_e%0d", k), 2'b00, 2'b00, 1'b0, 1'b0);
    end
    btn_up = 0; TopeA_S = 1;
    tick();
    check_out("limit_after_latency", 2'b00, 2'b00, 1'b0, 1'b0);
    TopeA_S = 0;
    repeat (10) tick();

    // Randomized phase, every edge compared against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) btn_up   = ~btn_up;
      if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 9) == 0) btn_stop = ~btn_stop;
      if ($urandom_range(0, 7) == 0) TopeA_S  = ~TopeA_S;
      if ($urandom_range(0, 7) == 0) TopeB_S  = ~TopeB_S;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
